i8080_fetch_aligner: RTL



---
 rtl/i8080_pkg.sv | 52 +++++
 rtl/i8080_len_decode.sv | 11 +
 rtl/i8080_fetch_aligner.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/i8080_pkg.sv
// Shared 8080 front-end types: opcode constants, instruction length type and
// the opcode -> instruction length classification.
package i8080_pkg;

    typedef logic [1:0] inst_len_t;

    localparam inst_len_t LEN1 = 2'd1;
    localparam inst_len_t LEN2 = 2'd2;
    localparam inst_len_t LEN3 = 2'd3;

    localparam logic [7:0] OP_HLT      = 8'h76;
    localparam logic [7:0] OP_OUT      = 8'hD3;
    localparam logic [7:0] OP_IN       = 8'hDB;
    localparam logic [7:0] OP_SHLD     = 8'h22;
    localparam logic [7:0] OP_LHLD     = 8'h2A;
    localparam logic [7:0] OP_STA      = 8'h32;
    localparam logic [7:0] OP_LDA      = 8'h3A;
    localparam logic [7:0] OP_JMP      = 8'hC3;
    localparam logic [7:0] OP_JMP_ALT  = 8'hCB;
    localparam logic [7:0] OP_CALL     = 8'hCD;
    localparam logic [7:0] OP_CALL_DD  = 8'hDD;
    localparam logic [7:0] OP_CALL_ED  = 8'hED;
    localparam logic [7:0] OP_CALL_FD  = 8'hFD;

    // Instruction word handed to decode: opcode first, then operand bytes.
    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] lo;
        logic [7:0] hi;
    } inst_bytes_t;

    // Immediate forms (MVI, ALU-immediate) and port I/O carry one operand byte;
    // 16-bit address/data forms and the undocumented CB/DD/ED/FD carry two.
    function automatic inst_len_t inst_len_of(input logic [7:0] op);
        inst_len_t len;
        len = LEN1;
        casez (op)
            8'b00???110, 8'b11???110, OP_OUT, OP_IN:
                len = LEN2;
            8'b00??0001, 8'b11???010, 8'b11???100,
            OP_SHLD, OP_LHLD, OP_STA, OP_LDA,
            OP_JMP, OP_JMP_ALT, OP_CALL, OP_CALL_DD, OP_CALL_ED, OP_CALL_FD:
                len = LEN3;
            OP_HLT:
                len = LEN1;
            default:
                len = LEN1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/i8080_len_decode.sv
// Combinational opcode length classifier, shared by fetch and decode.
module i8080_len_decode
    import i8080_pkg::*;
(
    input  logic [7:0] opcode_i,
    output inst_len_t  inst_len_o
);

    assign inst_len_o = inst_len_of(opcode_i);

endmodule

// File: rtl/i8080_fetch_aligner.sv
// Byte-queue fetch front end: wide memory words in, one 1..3 byte instruction
// out per handshake. Define I8080_FETCH_HLT_STOP_EN to stall fetch after HLT.
module i8080_fetch_aligner
    import i8080_pkg::*;
#(
    parameter int unsigned FETCH_BYTES = 2,
    parameter int unsigned QUEUE_DEPTH = 8,
    parameter logic [15:0] RESET_PC    = 16'h0000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_valid,
    input  logic [15:0]              redirect_pc,
    output logic                     mem_req,
    output logic [15:0]              mem_addr,
    input  logic                     mem_rvalid,
    input  logic [8*FETCH_BYTES-1:0] mem_rdata,
    output logic                     inst_valid,
    input  logic                     inst_ready,
    output logic [23:0]              inst_bytes,
    output logic [1:0]               inst_len,
    output logic [15:0]              inst_pc
);

    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;
    localparam int unsigned OFF_W = (FETCH_BYTES > 1) ? $clog2(FETCH_BYTES) : 1;

    localparam logic [15:0]      OFF_MASK   = 16'(FETCH_BYTES - 1);
    localparam logic [15:0]      ALIGN_MASK = ~OFF_MASK;
    localparam logic [SUM_W-1:0] FB_S       = SUM_W'(FETCH_BYTES);
    localparam logic [SUM_W-1:0] QD_S       = SUM_W'(QUEUE_DEPTH);
    localparam logic [CNT_W-1:0] FB_C       = CNT_W'(FETCH_BYTES);

    logic [7:0]       queue_q [QUEUE_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             inflight_q, inflight_d;
    logic             epoch_q, epoch_d;
    logic             req_epoch_q, req_epoch_d;
    logic [15:0]      fetch_addr_q, fetch_addr_d;
    logic [OFF_W-1:0] skip_q, skip_d;
    logic [15:0]      head_pc_q, head_pc_d;

    logic [7:0]       head0, head1, head2;
    inst_len_t        head_len;
    logic             space_ok;
    logic             halt_stop;
    logic             pop;
    logic             wr_en;
    logic [CNT_W-1:0] wr_num;
    inst_bytes_t      head_word;

    assign head0 = queue_q[rd_ptr_q];
    assign head1 = queue_q[rd_ptr_q + PTR_W'(1)];
    assign head2 = queue_q[rd_ptr_q + PTR_W'(2)];

    i8080_len_decode u_len_decode (
        .opcode_i   (head0),
        .inst_len_o (head_len)
    );

    // Reserve room for the in-flight word so a response can never overflow.
    assign space_ok = (SUM_W'(count_q) + (inflight_q ? FB_S : '0) + FB_S) <= QD_S;
    assign mem_req  = !rst && !redirect_valid && !halt_stop && space_ok;
    assign mem_addr = fetch_addr_q;

    assign inst_valid = !halt_stop && (count_q >= CNT_W'(head_len));
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign wr_en      = mem_rvalid && inflight_q && (req_epoch_q == epoch_q) && !redirect_valid;
    assign wr_num     = FB_C - CNT_W'(skip_q);

    always_comb begin
        head_word        = '0;
        head_word.opcode = head0;
        if (head_len != LEN1) head_word.lo = head1;
        if (head_len == LEN3) head_word.hi = head2;
    end

    assign inst_bytes = inst_valid ? head_word : '0;
    assign inst_len   = head_len;
    assign inst_pc    = head_pc_q;

`ifdef I8080_FETCH_HLT_STOP_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if (redirect_valid) begin
            halted_d = 1'b0;
        end else if (pop && head0 == OP_HLT) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) halted_q <= 1'b0;
        else     halted_q <= halted_d;
    end

    assign halt_stop = halted_q;
`else
    assign halt_stop = 1'b0;
`endif

    // Next-state: redirect wins over response write and pop.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        epoch_d      = epoch_q;
        fetch_addr_d = fetch_addr_q;
        skip_d       = skip_q;
        head_pc_d    = head_pc_q;
        inflight_d   = mem_req;
        req_epoch_d  = mem_req ? epoch_q : req_epoch_q;

        if (redirect_valid) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            epoch_d      = ~epoch_q;
            fetch_addr_d = redirect_pc & ALIGN_MASK;
            skip_d       = OFF_W'(redirect_pc & OFF_MASK);
            head_pc_d    = redirect_pc;
        end else begin
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(wr_num);
                skip_d   = '0;
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PTR_W'(head_len);
                head_pc_d = head_pc_q + 16'(head_len);
            end
            count_d = count_q + (wr_en ? wr_num : '0) - (pop ? CNT_W'(head_len) : '0);
            if (mem_req) fetch_addr_d = fetch_addr_q + 16'(FETCH_BYTES);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            inflight_q   <= 1'b0;
            epoch_q      <= 1'b0;
            req_epoch_q  <= 1'b0;
            fetch_addr_q <= RESET_PC & ALIGN_MASK;
            skip_q       <= OFF_W'(RESET_PC & OFF_MASK);
            head_pc_q    <= RESET_PC;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            inflight_q   <= inflight_d;
            epoch_q      <= epoch_d;
            req_epoch_q  <= req_epoch_d;
            fetch_addr_q <= fetch_addr_d;
            skip_q       <= skip_d;
            head_pc_q    <= head_pc_d;
        end
    end

    // Byte storage; the leading skip bytes of a response are not written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(QUEUE_DEPTH); i++) queue_q[i] <= '0;
        end else if (wr_en) begin
            for (int k = 0; k < int'(FETCH_BYTES); k++) begin
                if (k >= int'(skip_q)) begin
                    queue_q[wr_ptr_q + PTR_W'(k) - PTR_W'(skip_q)] <= mem_rdata[8*k +: 8];
                end
            end
        end
    end

endmodule
